// File: rtl/reloc_data_ram.sv
// Data memory with per-process base relocation, registered 1-cycle reads and range-fault capture.
// Optional macro LIMIT_CHECK_EN adds a per-process logical limit register loaded with the base.
module reloc_data_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3179
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              base_load,
    input  logic [DATA_W-1:0] proc_base,
    input  logic [ADDR_W-1:0] proc_limit,
    output logic [ADDR_W-1:0] cur_base,
    output logic              in_program,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] phys;
    logic              limit_ok;
    logic              legal;
    logic              illegal;

    // Relocation wraps modulo 2**ADDR_W; only the range checks decide legality.
    assign phys    = addr + cur_base;
    assign legal   = ({1'b0, phys} < DEPTH_L) && limit_ok;
    assign illegal = (wr_en || rd_en) && !legal;

    // Upper base bits are architecturally ignored.
    logic unused_base_hi;
    assign unused_base_hi = ^proc_base[DATA_W-1:ADDR_W];

`ifdef LIMIT_CHECK_EN
    logic [ADDR_W-1:0] limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit <= '1;
        end else if (base_load) begin
            limit <= proc_limit;
        end
    end

    assign limit_ok = (addr <= limit);
`else
    logic unused_limit;
    assign unused_limit = ^proc_limit;
    assign limit_ok     = 1'b1;
`endif

    // NOTE: the memory array has no reset so it can map onto block RAM; contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (wr_en && legal) begin
            mem[phys] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments make a same-edge read see the old word, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= legal ? mem[phys] : '0;
            end
        end
    end

    // Same-cycle accesses still see the old base because phys is built from the registered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_base   <= '0;
            in_program <= 1'b0;
        end else if (base_load) begin
            cur_base   <= proc_base[ADDR_W-1:0];
            in_program <= |proc_base[ADDR_W-1:0];
        end
    end

    // A new violation beats a simultaneous clear; otherwise the first address is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (illegal) begin
            fault <= 1'b1;
            if (!fault || fault_clr) begin
                fault_addr <= addr;
            end
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end
    end

endmodule

// File: tb/tb_reloc_data_ram.sv
// Self-checking bench for reloc_data_ram: directed vector table, limit/reset sequences, random vs. model.
module tb_reloc_data_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 3179;

`ifdef LIMIT_CHECK_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              base_load = 1'b0;
    logic [DATA_W-1:0] proc_base = '0;
    logic [ADDR_W-1:0] proc_limit = '1;
    logic [ADDR_W-1:0] cur_base;
    logic              in_program;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;
    logic              fault_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    reloc_data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .base_load(base_load),
        .proc_base(proc_base), .proc_limit(proc_limit), .cur_base(cur_base),
        .in_program(in_program), .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd, wr, bl, clr;
        logic [11:0] a;
        logic [31:0] wd;
        logic [11:0] pb;
        logic        chk_rd;
        logic        ev;
        logic [31:0] ed;
        logic        ef;
        logic [11:0] efa;
        logic [11:0] eb;
        logic        eip;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 0; wr_en = 0; base_load = 0; fault_clr = 0;
    endtask

    task automatic add(input string n, input logic rd, input logic wr, input logic bl, input logic clr,
                       input logic [11:0] a, input logic [31:0] wd, input logic [11:0] pb,
                       input logic chk, input logic ev, input logic [31:0] ed, input logic ef,
                       input logic [11:0] efa, input logic [11:0] eb, input logic eip);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.bl = bl; v.clr = clr; v.a = a; v.wd = wd; v.pb = pb;
        v.chk_rd = chk; v.ev = ev; v.ed = ed; v.ef = ef; v.efa = efa; v.eb = eb; v.eip = eip;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // Behavioural reference for the random phase
    logic [31:0] m_mem [4096];
    bit          m_known [4096];
    logic [11:0] m_base, m_limit, m_faddr;
    logic        m_fault, m_valid, m_dknown;
    logic [31:0] m_data;

    initial begin
        logic [11:0] bases [5];
        bases[0] = 12'h000; bases[1] = 12'h010; bases[2] = 12'h020;
        bases[3] = 12'hC60; bases[4] = 12'hFF0;

        // ---------------- reset state
        do_reset();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_cur_base", cur_base, 0);
        check("rst_in_program", in_program, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_addr", fault_addr, 0);

        // ---------------- directed table        rd wr bl clr addr     wdata         pbase  chk v  data         f  faddr   base   ip
        add("wr_deadbeef",   0, 1, 0, 0, 12'h010, 32'hDEADBEEF, 12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("rd_deadbeef",   1, 0, 0, 0, 12'h010, 32'h0,        12'h000, 1, 1, 32'hDEADBEEF, 0, 12'h000, 12'h000, 0);
        add("idle_hold",     0, 0, 0, 0, 12'h000, 32'h0,        12'h000, 1, 0, 32'hDEADBEEF, 0, 12'h000, 12'h000, 0);
        add("wr_201_zero",   0, 1, 0, 0, 12'h201, 32'h0,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("bl_100",        0, 0, 1, 0, 12'h000, 32'h0,        12'h100, 0, 0, 32'h0,        0, 12'h000, 12'h100, 1);
        add("wr_005",        0, 1, 0, 0, 12'h005, 32'h12345678, 12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h100, 1);
        add("bl_0",          0, 0, 1, 0, 12'h000, 32'h0,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("rd_105",        1, 0, 0, 0, 12'h105, 32'h0,        12'h000, 1, 1, 32'h12345678, 0, 12'h000, 12'h000, 0);
        add("bl200_wr001",   0, 1, 1, 0, 12'h001, 32'hA5A5A5A5, 12'h200, 0, 0, 32'h0,        0, 12'h000, 12'h200, 1);
        add("bl_0b",         0, 0, 1, 0, 12'h000, 32'h0,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("rd_001",        1, 0, 0, 0, 12'h001, 32'h0,        12'h000, 1, 1, 32'hA5A5A5A5, 0, 12'h000, 12'h000, 0);
        add("rd_201",        1, 0, 0, 0, 12'h201, 32'h0,        12'h000, 1, 1, 32'h0,        0, 12'h000, 12'h000, 0);
        add("bl_c00",        0, 0, 1, 0, 12'h000, 32'h0,        12'hC00, 0, 0, 32'h0,        0, 12'h000, 12'hC00, 1);
        add("rd_fault",      1, 0, 0, 0, 12'h100, 32'h0,        12'h000, 1, 1, 32'h0,        1, 12'h100, 12'hC00, 1);
        add("rd_fault2",     1, 0, 0, 0, 12'h101, 32'h0,        12'h000, 1, 1, 32'h0,        1, 12'h100, 12'hC00, 1);
        add("clr",           0, 0, 0, 1, 12'h000, 32'h0,        12'h000, 1, 0, 32'h0,        0, 12'h000, 12'hC00, 1);
        add("clr_and_fault", 1, 0, 0, 1, 12'h102, 32'h0,        12'h000, 1, 1, 32'h0,        1, 12'h102, 12'hC00, 1);
        add("wr_wrap",       0, 1, 0, 0, 12'h500, 32'hCAFEF00D, 12'h000, 0, 0, 32'h0,        1, 12'h102, 12'hC00, 1);
        add("clr2",          0, 0, 0, 1, 12'h000, 32'h0,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'hC00, 1);
        add("bl_0c",         0, 0, 1, 0, 12'h000, 32'h0,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("rd_wrap",       1, 0, 0, 0, 12'h100, 32'h0,        12'h000, 1, 1, 32'hCAFEF00D, 0, 12'h000, 12'h000, 0);
        add("wr_020_1",      0, 1, 0, 0, 12'h020, 32'h1,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("rw_same",       1, 1, 0, 0, 12'h020, 32'h2,        12'h000, 1, 1, 32'h1,        0, 12'h000, 12'h000, 0);
        add("rd_020",        1, 0, 0, 0, 12'h020, 32'h0,        12'h000, 1, 1, 32'h2,        0, 12'h000, 12'h000, 0);
        add("wr_last",       0, 1, 0, 0, 12'hC6A, 32'h5A5A0001, 12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);
        add("rd_last",       1, 0, 0, 0, 12'hC6A, 32'h0,        12'h000, 1, 1, 32'h5A5A0001, 0, 12'h000, 12'h000, 0);
        add("wr_oob",        0, 1, 0, 0, 12'hC6B, 32'hFFFFFFFF, 12'h000, 0, 0, 32'h0,        1, 12'hC6B, 12'h000, 0);
        add("rd_oob",        1, 0, 0, 0, 12'hC6B, 32'h0,        12'h000, 1, 1, 32'h0,        1, 12'hC6B, 12'h000, 0);
        add("clr3",          0, 0, 0, 1, 12'h000, 32'h0,        12'h000, 0, 0, 32'h0,        0, 12'h000, 12'h000, 0);

        proc_limit = '1;
        for (int i = 0; i < vq.size(); i++) begin
            rd_en = vq[i].rd; wr_en = vq[i].wr; base_load = vq[i].bl; fault_clr = vq[i].clr;
            addr = vq[i].a; wr_data = vq[i].wd; proc_base = {20'hABCDE, vq[i].pb};
            tick();
            check({vq[i].name, ".rd_valid"}, rd_valid, vq[i].ev);
            if (vq[i].chk_rd) check({vq[i].name, ".rd_data"}, rd_data, vq[i].ed);
            check({vq[i].name, ".fault"}, fault, vq[i].ef);
            check({vq[i].name, ".fault_addr"}, fault_addr, vq[i].efa);
            check({vq[i].name, ".cur_base"}, cur_base, vq[i].eb);
            check({vq[i].name, ".in_program"}, in_program, vq[i].eip);
        end
        idle();

        // ---------------- limit check (behaviour depends on LIMIT_CHECK_EN)
        wr_en = 1; addr = 12'h050; wr_data = 32'h11;
        tick();
        idle();
        base_load = 1; proc_base = 32'h040; proc_limit = 12'h00F;
        tick();
        idle();
        check("lim_base", cur_base, 12'h040);
        wr_en = 1; addr = 12'h010; wr_data = 32'h77;
        tick();
        check("lim_wr_over_fault", fault, LIM);
        check("lim_wr_over_faddr", fault_addr, LIM ? 12'h010 : 12'h000);
        wr_en = 1; addr = 12'h00F; wr_data = 32'h66;
        tick();
        check("lim_wr_edge_fault", fault, LIM);
        wr_en = 0; rd_en = 1; addr = 12'h010;
        tick();
        check("lim_rd_over_valid", rd_valid, 1);
        check("lim_rd_over_data", rd_data, LIM ? 32'h0 : 32'h77);
        addr = 12'h00F;
        tick();
        check("lim_rd_edge_data", rd_data, 32'h66);
        idle();
        fault_clr = 1; base_load = 1; proc_base = 32'h0; proc_limit = 12'hFFF;
        tick();
        idle();
        check("lim_clr_fault", fault, 0);
        rd_en = 1; addr = 12'h050;
        tick();
        idle();
        check("lim_phys_050", rd_data, LIM ? 32'h11 : 32'h77);

        // ---------------- reset asserted mid-read
        base_load = 1; proc_base = 32'h300;
        tick();
        idle();
        rd_en = 1; addr = 12'h000;
        tick();
        check("mid_rst_pre_valid", rd_valid, 1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_valid_drop", rd_valid, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_base", cur_base, 0);
        check("mid_rst_in_program", in_program, 0);
        tick();
        rst_n = 1; rd_en = 0;
        tick();
        check("post_rst_valid", rd_valid, 0);
        check("post_rst_data", rd_data, 0);

        // ---------------- random stimulus against the reference model
        do_reset();
        for (int i = 0; i < 4096; i++) m_known[i] = 0;
        m_base = 0; m_limit = '1; m_fault = 0; m_faddr = 0;
        m_valid = 0; m_data = 0; m_dknown = 1;
        for (int n = 0; n < 3000; n++) begin
            int  p;
            bit  lg;
            rd_en     = ($urandom_range(0, 99) < 45);
            wr_en     = ($urandom_range(0, 99) < 40);
            addr      = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            wr_data   = $urandom;
            base_load = ($urandom_range(0, 19) == 0);
            proc_base = {20'($urandom), bases[$urandom_range(0, 4)]};
            proc_limit = $urandom_range(0, 1) ? 12'hFFF : 12'($urandom_range(0, 80));
            fault_clr = ($urandom_range(0, 14) == 0);

            p  = (int'(addr) + int'(m_base)) % 4096;
            lg = (p < DEPTH) && (!LIM || addr <= m_limit);
            m_valid = rd_en;
            if (rd_en) begin
                m_dknown = lg ? m_known[p] : 1'b1;
                m_data   = lg ? m_mem[p] : 32'h0;
            end
            if ((rd_en || wr_en) && !lg) begin
                if (!m_fault || fault_clr) m_faddr = addr;
                m_fault = 1;
            end else if (fault_clr) begin
                m_fault = 0;
                m_faddr = 0;
            end
            if (wr_en && lg) begin
                m_mem[p]   = wr_data;
                m_known[p] = 1;
            end
            if (base_load) begin
                m_base  = proc_base[11:0];
                m_limit = proc_limit;
            end

            tick();
            check("rnd_rd_valid", rd_valid, m_valid);
            if (m_dknown) check("rnd_rd_data", rd_data, m_data);
            check("rnd_fault", fault, m_fault);
            check("rnd_fault_addr", fault_addr, m_faddr);
            check("rnd_cur_base", cur_base, m_base);
            check("rnd_in_program", in_program, m_base != 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
